// File: rtl/offset_pipe_pkg.sv
// Shared types and widths for the offset_pipe datapath.
package offset_pipe_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int UF_CNT_W = 16;

endpackage

// File: rtl/offset_pipe_slot.sv
// One elastic register slot: a valid bit plus a data word.
// clear empties the slot (bubble), load captures a new beat; data holds otherwise.
module pipe_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             vld,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end
  end

endmodule

// File: rtl/offset_pipe.sv
// Elastic STAGES-slot pipeline subtracting a constant OFFSET, with a per-beat
// underflow flag and a saturating count of delivered underflow beats.
module offset_pipe
  import offset_pipe_pkg::*;
#(
  parameter int    WIDTH  = 8,
  parameter int    STAGES = 2,
  parameter int    OFFSET = 16,
  parameter mode_e MODE   = MODE_WRAP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    data_out,
  output logic                underflow,
  input  logic                clr_count,
  output logic [UF_CNT_W-1:0] uf_count
);

  // vld_pipe[0]/dat_pipe[0] is the upstream port; entry k+1 is slot k.
  logic [STAGES:0]              vld_pipe;
  logic [STAGES-1:0][WIDTH-1:0] dat_pipe;
  logic [STAGES-1:0]            adv;
  logic [WIDTH:0]               last_q;
  logic [WIDTH:0]               diff;
  logic                         uf_next;
  logic [WIDTH-1:0]             res_next;

  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = data_in;

  // Arithmetic sits in front of the last slot so the result leaves registered.
  assign diff     = {1'b0, dat_pipe[STAGES-1]} - (WIDTH+1)'(OFFSET);
  assign uf_next  = diff[WIDTH];
  assign res_next = (MODE == MODE_SAT && uf_next) ? '0 : diff[WIDTH-1:0];

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == STAGES-1) begin : g_last
        assign adv[k] = !vld_pipe[k+1] || out_ready;
        pipe_slot #(.WIDTH(WIDTH+1)) u_slot (
          .clk   (clk),
          .rst   (rst),
          .load  (adv[k] && vld_pipe[k]),
          .clear (adv[k] && !vld_pipe[k]),
          .d     ({uf_next, res_next}),
          .vld   (vld_pipe[k+1]),
          .q     (last_q)
        );
      end else begin : g_mid
        assign adv[k] = !vld_pipe[k+1] || adv[k+1];
        pipe_slot #(.WIDTH(WIDTH)) u_slot (
          .clk   (clk),
          .rst   (rst),
          .load  (adv[k] && vld_pipe[k]),
          .clear (adv[k] && !vld_pipe[k]),
          .d     (dat_pipe[k]),
          .vld   (vld_pipe[k+1]),
          .q     (dat_pipe[k+1])
        );
      end
    end
  endgenerate

  assign in_ready  = adv[0];
  assign out_valid = vld_pipe[STAGES];
  assign data_out  = last_q[WIDTH-1:0];
  // A bubble keeps stale slot data, so the flag is masked by valid.
  assign underflow = last_q[WIDTH] && out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      uf_count <= '0;
    else if (clr_count)
      uf_count <= '0;
    else if (out_valid && out_ready && underflow && uf_count != '1)
      uf_count <= uf_count + 1'b1;
  end

endmodule
